// File: rtl/numitron_pkg.sv
// Shared definitions for the button event decoder: FSM state codes and
// the hold-counter width derivation.
package numitron_pkg;

   // Button event FSM states
   localparam logic [1:0] ST_WAIT_REL  = 2'd0;  // armed only after a low sample
   localparam logic [1:0] ST_IDLE      = 2'd1;  // released, waiting for a press
   localparam logic [1:0] ST_PRESSED   = 2'd2;  // held, below the long threshold
   localparam logic [1:0] ST_REPEATING = 2'd3;  // long press seen, auto-repeating

   // Hold counter must be able to represent LONG_CYCLES+REPEAT_CYCLES.
   function automatic int hold_cnt_width(input int long_cycles, input int repeat_cycles);
      return $clog2(long_cycles + repeat_cycles + 1);
   endfunction

endpackage

// File: rtl/button_event.sv
// Button event decoder: turns a debounced button level into short-press,
// long-press and auto-repeat strobes. Sits directly after button_debounce.
// All outputs are registered; each strobe lasts exactly one cycle and at
// most one strobe is high in any cycle.
module button_event
   import numitron_pkg::*;
#(
   parameter int MIN_CYCLES    = 20,
   parameter int LONG_CYCLES   = 1000,
   parameter int REPEAT_CYCLES = 250
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_level,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int CW = hold_cnt_width(LONG_CYCLES, REPEAT_CYCLES);

   localparam logic [CW-1:0] MIN_C   = CW'(MIN_CYCLES);
   localparam logic [CW-1:0] LONG_C  = CW'(LONG_CYCLES);
   localparam logic [CW-1:0] REP_C   = CW'(REPEAT_CYCLES);
   localparam logic [CW-1:0] SAT_C   = CW'(LONG_CYCLES + REPEAT_CYCLES);

   logic [1:0]    state;
   logic [CW-1:0] count;
   logic [CW-1:0] count_inc;

   // Saturating increment of the hold counter.
   always_comb begin
      count_inc = count;
      if (count != SAT_C) begin
         count_inc = count + 1'b1;
      end
   end

   // Press-tracking FSM with registered strobes and held flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= ST_WAIT_REL;
         count        <= '0;
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         held         <= 1'b0;
      end else begin
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         case (state)
            ST_WAIT_REL: begin
               // A button held through reset must be released before it counts.
               if (!btn_level) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (btn_level) begin
                  state <= ST_PRESSED;
                  count <= CW'(1);
                  held  <= 1'b1;
               end
            end
            ST_PRESSED: begin
               if (btn_level) begin
                  if (count_inc == LONG_C) begin
                     long_pulse <= 1'b1;
                     state      <= ST_REPEATING;
                     count      <= '0;
                  end else begin
                     count <= count_inc;
                  end
               end else begin
                  // Releases shorter than MIN_CYCLES are treated as glitches.
                  if ((count >= MIN_C) && (count < LONG_C)) begin
                     short_pulse <= 1'b1;
                  end
                  state <= ST_IDLE;
                  count <= '0;
                  held  <= 1'b0;
               end
            end
            ST_REPEATING: begin
               if (btn_level) begin
                  if (count_inc == REP_C) begin
                     repeat_pulse <= 1'b1;
                     count        <= '0;
                  end else begin
                     count <= count_inc;
                  end
               end else begin
                  state <= ST_IDLE;
                  count <= '0;
                  held  <= 1'b0;
               end
            end
            default: begin
               state <= ST_WAIT_REL;
               count <= '0;
               held  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event with MIN=4, LONG=16, REPEAT=8.
// A reference model derives expected strobes from the length of the
// current run of high samples; directed scenarios also check event totals.
module tb_button_event;

   localparam int MIN_C  = 4;
   localparam int LONG_C = 16;
   localparam int REP_C  = 8;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic btn_level = 1'b0;
   logic short_pulse;
   logic long_pulse;
   logic repeat_pulse;
   logic held;

   int checks = 0;
   int errors = 0;

   // Event tallies observed from the DUT, cleared per scenario.
   int n_short = 0;
   int n_long  = 0;
   int n_rep   = 0;
   int n_held  = 0;

   // Reference model: armed after a low sample post-reset; run = highs in current press.
   bit m_armed = 1'b0;
   int m_run   = 0;

   // Clock generation.
   always #5 clk = ~clk;

   button_event #(
      .MIN_CYCLES   (MIN_C),
      .LONG_CYCLES  (LONG_C),
      .REPEAT_CYCLES(REP_C)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .btn_level   (btn_level),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .repeat_pulse(repeat_pulse),
      .held        (held)
   );

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at %0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_tally();
      n_short = 0;
      n_long  = 0;
      n_rep   = 0;
      n_held  = 0;
   endtask

   // Drive one sample, advance one edge, update the model, compare after the edge.
   task automatic step(input logic r, input logic b);
      logic e_s, e_l, e_r, e_h;
      e_s = 1'b0;
      e_l = 1'b0;
      e_r = 1'b0;
      e_h = 1'b0;
      rstn      = r;
      btn_level = b;
      @(posedge clk);
      if (!r) begin
         m_armed = 1'b0;
         m_run   = 0;
      end else if (!m_armed) begin
         if (!b) m_armed = 1'b1;
      end else if (b) begin
         m_run = m_run + 1;
         e_h   = 1'b1;
         e_l   = (m_run == LONG_C);
         e_r   = (m_run > LONG_C) && (((m_run - LONG_C) % REP_C) == 0);
      end else begin
         e_s   = (m_run >= MIN_C) && (m_run < LONG_C);
         m_run = 0;
      end
      @(negedge clk);
      check_bit("short_pulse", short_pulse, e_s);
      check_bit("long_pulse", long_pulse, e_l);
      check_bit("repeat_pulse", repeat_pulse, e_r);
      check_bit("held", held, e_h);
      check_bit("one_strobe_max", (32'(short_pulse) + 32'(long_pulse) + 32'(repeat_pulse)) <= 1, 1'b1);
      n_short += 32'(short_pulse);
      n_long  += 32'(long_pulse);
      n_rep   += 32'(repeat_pulse);
      n_held  += 32'(held);
   endtask

   task automatic hold_high(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1);
   endtask

   initial begin
      // Reset state
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);

      // Short press of 6 samples
      clear_tally();
      hold_high(6);
      step(1'b1, 1'b0);
      check_bit("short_after_release", short_pulse, 1'b1);
      step(1'b1, 1'b0);
      check_int("short6_n_short", n_short, 1);
      check_int("short6_n_held", n_held, 6);
      check_int("short6_n_long", n_long, 0);

      // Glitch of 3 samples
      clear_tally();
      hold_high(3);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_int("glitch_pulses", n_short + n_long + n_rep, 0);

      // Long hold of 40 samples
      clear_tally();
      hold_high(40);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_int("long40_n_long", n_long, 1);
      check_int("long40_n_rep", n_rep, 3);
      check_int("long40_n_short", n_short, 0);

      // Held through reset, then release and a short press
      clear_tally();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      hold_high(30);
      check_int("held_thru_reset_quiet", n_short + n_long + n_rep + n_held, 0);
      step(1'b1, 1'b0);
      hold_high(6);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_int("after_reset_n_short", n_short, 1);

      // Reset mid-press at count 10
      clear_tally();
      hold_high(10);
      step(1'b0, 1'b1);
      check_bit("midreset_held", held, 1'b0);
      hold_high(5);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_int("midreset_pulses", n_short + n_long + n_rep, 0);

      // Release at count 15, then immediate re-press counted from 1
      clear_tally();
      hold_high(15);
      step(1'b1, 1'b0);
      check_bit("rel15_short", short_pulse, 1'b1);
      hold_high(15);
      check_int("repress_no_long_yet", n_long, 0);
      step(1'b1, 1'b1);
      check_bit("repress_long_at_16", long_pulse, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_int("rel15_n_short", n_short, 1);
      check_int("rel15_n_long", n_long, 1);

      // Randomized runs checked against the model
      for (int k = 0; k < 60; k++) begin
         int hi_len;
         int lo_len;
         hi_len = $urandom_range(1, 45);
         lo_len = $urandom_range(1, 3);
         for (int i = 0; i < hi_len; i++) begin
            if ($urandom_range(0, 99) == 0) step(1'b0, 1'b1);
            else step(1'b1, 1'b1);
         end
         for (int i = 0; i < lo_len; i++) step(1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
